// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the RV32I memory responder.
// The fault rule lives here so the FSM can classify a request in its acceptance cycle.
package mem_responder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_CAPTURE,
    S_DONE
  } MemState;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int WaitCntSize = 4;
  localparam int RamBeWidth  = 4;

  // Misaligned halves/words, reserved encodings and unsigned "stores" all fault.
  function automatic logic access_fault(input logic [2:0] funct3,
                                        input logic [1:0] addr_lo,
                                        input logic       write);
    logic bad;
    case (funct3)
      F3_LB:   bad = 1'b0;
      F3_LH:   bad = addr_lo[0];
      F3_LW:   bad = |addr_lo;
      F3_LBU:  bad = write;
      F3_LHU:  bad = write | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Core-side strobes and load result plus the block RAM port, bundled as one bus.
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 10
) ();

  logic                  mem_rd_i;
  logic                  mem_wr_i;
  logic [DATA_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic [2:0]            funct3_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  mem_busy_o;
  logic                  fault_o;
  logic                  ram_en_o;
  logic [RamBeWidth-1:0] ram_we_o;
  logic [ADDR_BITS-1:0]  ram_addr_o;
  logic [DATA_WIDTH-1:0] ram_wdata_o;
  logic [DATA_WIDTH-1:0] ram_rdata_i;

  modport slave (
    input  mem_rd_i, mem_wr_i, addr_i, wr_data_i, funct3_i, ram_rdata_i,
    output rd_data_o, mem_busy_o, fault_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
  );

  modport master (
    output mem_rd_i, mem_wr_i, addr_i, wr_data_i, funct3_i, ram_rdata_i,
    input  rd_data_o, mem_busy_o, fault_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte/half/word lane handling: load extract with sign/zero extension and
// store replication with the matching byte-enable mask.
module mem_lane_align
  import mem_responder_pkg::*;
(
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [31:0]           wr_data,
  input  logic [31:0]           ram_rdata,
  output logic [31:0]           load_data,
  output logic [31:0]           store_data,
  output logic [RamBeWidth-1:0] byte_en
);

  logic [15:0] lane_half;
  logic [7:0]  lane_byte;

  always_comb begin
    lane_half = addr_lo[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    lane_byte = addr_lo[0] ? lane_half[15:8] : lane_half[7:0];

    case (funct3)
      F3_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      F3_LBU:  load_data = {24'h0, lane_byte};
      F3_LHU:  load_data = {16'h0, lane_half};
      default: load_data = ram_rdata;
    endcase

    // The RAM only commits the enabled lanes, so the data is simply replicated.
    case (funct3)
      F3_SB: begin
        store_data = {4{wr_data[7:0]}};
        byte_en    = RamBeWidth'(1) << addr_lo;
      end
      F3_SH: begin
        store_data = {2{wr_data[15:0]}};
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      F3_SW: begin
        store_data = wr_data;
        byte_en    = 4'b1111;
      end
      default: begin
        store_data = wr_data;
        byte_en    = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle RV32I core: accepts one strobe-edge
// request at a time, drives the synchronous block RAM and returns aligned load data.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk_i,
  input  logic          reset_i,
  mem_responder_if.slave bus
);

  localparam int AddrLatchBits = ADDR_BITS + 2;
  localparam logic [WaitCntSize-1:0] WaitInit = WaitCntSize'(WAIT_STATES);

  MemState                  state;
  logic                     armed;
  logic                     lat_write;
  logic [AddrLatchBits-1:0] lat_addr;
  logic [DATA_WIDTH-1:0]    lat_data;
  logic [2:0]               lat_funct3;
  logic [WaitCntSize-1:0]   wait_cnt;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     fault;
  logic                     ram_en;
  logic [RamBeWidth-1:0]    ram_we;
  logic [ADDR_BITS-1:0]     ram_addr;
  logic [DATA_WIDTH-1:0]    ram_wdata;

  logic                     in_idle;
  logic                     accept;
  logic                     issue;
  logic                     req_write;
  logic                     req_fault;
  logic [AddrLatchBits-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_data;
  logic [2:0]               req_funct3;
  logic [DATA_WIDTH-1:0]    load_data;
  logic [DATA_WIDTH-1:0]    store_data;
  logic [RamBeWidth-1:0]    byte_en;
  logic                     unused_addr_hi;

  // In Idle the live bus is the request; afterwards the latched copy is.
  always_comb begin
    in_idle    = state == S_IDLE;
    accept     = reset_i && in_idle && armed && (!bus.mem_rd_i || !bus.mem_wr_i);
    req_addr   = in_idle ? bus.addr_i[AddrLatchBits-1:0] : lat_addr;
    req_data   = in_idle ? bus.wr_data_i : lat_data;
    req_funct3 = in_idle ? bus.funct3_i : lat_funct3;
    req_write  = in_idle ? !bus.mem_wr_i : lat_write;
    req_fault  = access_fault(req_funct3, req_addr[1:0], req_write);
    issue      = (accept && !req_fault && WAIT_STATES == 0) ||
                 (state == S_WAIT && wait_cnt == WaitCntSize'(1));
  end

  assign unused_addr_hi = ^bus.addr_i[DATA_WIDTH-1:AddrLatchBits];

  mem_lane_align u_align (
    .funct3     (req_funct3),
    .addr_lo    (req_addr[1:0]),
    .wr_data    (req_data),
    .ram_rdata  (bus.ram_rdata_i),
    .load_data  (load_data),
    .store_data (store_data),
    .byte_en    (byte_en)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state      <= S_IDLE;
      armed      <= 1'b1;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_funct3 <= '0;
      wait_cnt   <= '0;
      rd_data    <= '0;
      fault      <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      fault  <= 1'b0;
      ram_en <= 1'b0;
      ram_we <= '0;
      if (bus.mem_rd_i && bus.mem_wr_i) armed <= 1'b1;

      if (issue) begin
        ram_en   <= 1'b1;
        ram_addr <= req_addr[AddrLatchBits-1:2];
        if (req_write) begin
          ram_we    <= byte_en;
          ram_wdata <= store_data;
        end
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_addr   <= req_addr;
            lat_data   <= req_data;
            lat_funct3 <= req_funct3;
            lat_write  <= req_write;
            armed      <= 1'b0;
            wait_cnt   <= WaitInit;
            if (req_fault) begin
              fault <= 1'b1;
              state <= S_DONE;
            end else if (WAIT_STATES > 0) begin
              state <= S_WAIT;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == WaitCntSize'(1)) state <= S_ACCESS;
          else                             wait_cnt <= wait_cnt - 1'b1;
        end
        S_ACCESS:  state <= lat_write ? S_DONE : S_CAPTURE;
        S_CAPTURE: begin
          rd_data <= load_data;
          state   <= S_DONE;
        end
        default:   state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_busy_o  = accept || (state inside {S_WAIT, S_ACCESS, S_CAPTURE});
  assign bus.rd_data_o   = rd_data;
  assign bus.fault_o     = fault;
  assign bus.ram_en_o    = ram_en;
  assign bus.ram_we_o    = ram_we;
  assign bus.ram_addr_o  = ram_addr;
  assign bus.ram_wdata_o = ram_wdata;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (0 and 3 wait states) share one request
// stream and are compared every cycle against a transaction-level model.
module tb_mem_responder;

  localparam int NWORDS = 1024;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rd_n, wr_n;
  logic [31:0] addr, wdata;
  logic [2:0]  f3;

  mem_responder_if #(.DATA_WIDTH(32), .ADDR_BITS(10)) bus0 ();
  mem_responder_if #(.DATA_WIDTH(32), .ADDR_BITS(10)) bus3 ();

  logic [31:0] rdata0, rdata3;
  assign bus0.mem_rd_i = rd_n;  assign bus3.mem_rd_i = rd_n;
  assign bus0.mem_wr_i = wr_n;  assign bus3.mem_wr_i = wr_n;
  assign bus0.addr_i = addr;    assign bus3.addr_i = addr;
  assign bus0.wr_data_i = wdata; assign bus3.wr_data_i = wdata;
  assign bus0.funct3_i = f3;    assign bus3.funct3_i = f3;
  assign bus0.ram_rdata_i = rdata0;
  assign bus3.ram_rdata_i = rdata3;

  mem_responder #(.DATA_WIDTH(32), .ADDR_BITS(10), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .reset_i(rst_n), .bus(bus0));
  mem_responder #(.DATA_WIDTH(32), .ADDR_BITS(10), .WAIT_STATES(3)) dut3 (
    .clk_i(clk), .reset_i(rst_n), .bus(bus3));

  // Physical block RAMs, one per instance, with a clear/preload back door.
  logic [31:0] ram0 [NWORDS];
  logic [31:0] ram3 [NWORDS];
  logic        ram_clr, pl_en;
  logic [9:0]  pl_idx;
  logic [31:0] pl_val;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < NWORDS; i++) begin
        ram0[i] <= '0;
        ram3[i] <= '0;
      end
    end else if (pl_en) begin
      ram0[pl_idx] <= pl_val;
      ram3[pl_idx] <= pl_val;
    end
    if (bus0.ram_en_o) begin
      rdata0 <= ram0[bus0.ram_addr_o];
      for (int b = 0; b < 4; b++)
        if (bus0.ram_we_o[b]) ram0[bus0.ram_addr_o][8*b +: 8] <= bus0.ram_wdata_o[8*b +: 8];
    end
    if (bus3.ram_en_o) begin
      rdata3 <= ram3[bus3.ram_addr_o];
      for (int b = 0; b < 4; b++)
        if (bus3.ram_we_o[b]) ram3[bus3.ram_addr_o][8*b +: 8] <= bus3.ram_wdata_o[8*b +: 8];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Spec-level model: memory image plus the current transaction's expectations.
  logic [31:0] model_mem [NWORDS];
  bit          in_reset, t_valid, t_write, t_fault;
  int          t_start;
  logic [31:0] t_load, t_wdata;
  logic [3:0]  t_we;
  logic [9:0]  t_idx;
  logic [31:0] exp_rd [2];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic int access_size(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit model_fault(input bit wr, input logic [2:0] f, input logic [31:0] a);
    int size = access_size(f);
    if (size == 0) return 1'b1;
    if (wr && f >= 3'd4) return 1'b1;
    return (a % size) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a);
    logic [31:0] w, v, mask;
    int size = access_size(f);
    w = model_mem[10'((a >> 2) % NWORDS)];
    if (size == 4) return w;
    mask = (32'd1 << (8 * size)) - 1;
    v = (w >> (8 * (a % 4))) & mask;
    if (f < 3'd4 && v[8*size-1]) v = v | ~mask;
    return v;
  endfunction

  // Record the request currently on the bus as the active transaction.
  task automatic record_txn();
    int size = access_size(f3);
    t_write = !wr_n;
    t_fault = model_fault(t_write, f3, addr);
    t_idx   = 10'((addr >> 2) % NWORDS);
    t_we    = '0;
    t_wdata = (size == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
              (size == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
    if (!t_fault && t_write) begin
      for (int i = 0; i < size; i++) begin
        int lane = int'((addr + 32'(i)) % 4);
        t_we = t_we | 4'(1 << lane);
        model_mem[t_idx][8*lane +: 8] = wdata[8*i +: 8];
      end
    end else if (!t_fault) begin
      t_load = model_load(f3, addr);
    end
    t_start = cyc;
    t_valid = 1'b1;
  endtask

  task automatic apply_stimulus(input bit rdn, input bit wrn, input logic [31:0] a,
                                input logic [31:0] d, input logic [2:0] f);
    @(posedge clk); #1;
    rd_n = rdn; wr_n = wrn; addr = a; wdata = d; f3 = f;
    record_txn();
    repeat (8) @(posedge clk);
    #1 rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic check_rd(input string name, input logic [31:0] lit);
    check_output({name, " w0"}, bus0.rd_data_o, lit);
    check_output({name, " w3"}, bus3.rd_data_o, lit);
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] val);
    pl_idx = idx; pl_val = val; pl_en = 1'b1;
    model_mem[idx] = val;
    @(posedge clk); #1 pl_en = 1'b0;
  endtask

  // Cycle-by-cycle compare: k counts cycles from the acceptance cycle.
  always @(negedge clk) begin
    if (in_reset) begin
      exp_rd[0] <= '0;
      exp_rd[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        automatic int    w = (i == 0) ? 0 : 3;
        automatic int    k = t_valid ? cyc - t_start : 1000;
        automatic int    done_k = t_fault ? 1 : (t_write ? 2 : 3) + w;
        automatic string tag = (i == 0) ? "w0" : "w3";
        automatic bit    e_en = t_valid && !t_fault && k == w + 1;
        automatic logic [31:0] e_rd = exp_rd[i];
        automatic logic        busy, en, flt;
        automatic logic [3:0]  we;
        automatic logic [9:0]  ra;
        automatic logic [31:0] wd, rd;
        if (i == 0) begin
          busy = bus0.mem_busy_o; en = bus0.ram_en_o; flt = bus0.fault_o;
          we = bus0.ram_we_o; ra = bus0.ram_addr_o; wd = bus0.ram_wdata_o; rd = bus0.rd_data_o;
        end else begin
          busy = bus3.mem_busy_o; en = bus3.ram_en_o; flt = bus3.fault_o;
          we = bus3.ram_we_o; ra = bus3.ram_addr_o; wd = bus3.ram_wdata_o; rd = bus3.rd_data_o;
        end
        if (t_valid && !t_fault && !t_write && k == done_k) e_rd = t_load;
        check_output({tag, " busy"}, 32'(busy), 32'(k < done_k));
        check_output({tag, " ram_en"}, 32'(en), 32'(e_en));
        check_output({tag, " ram_we"}, 32'(we), (e_en && t_write) ? 32'(t_we) : 32'd0);
        check_output({tag, " fault"}, 32'(flt), 32'(t_valid && t_fault && k == done_k));
        check_output({tag, " rd_data"}, rd, e_rd);
        if (e_en) check_output({tag, " ram_addr"}, 32'(ra), 32'(t_idx));
        if (e_en && t_write) check_output({tag, " ram_wdata"}, wd, t_wdata);
        exp_rd[i] <= e_rd;
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_reset = 1'b1; t_valid = 1'b0;
    rd_n = 1'b1; wr_n = 1'b1; addr = '0; wdata = '0; f3 = LW;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0; ram_clr = 1'b1;
    t_write = 1'b0; t_fault = 1'b0; t_start = 0; t_load = '0; t_wdata = '0; t_we = '0; t_idx = '0;
    for (int i = 0; i < NWORDS; i++) model_mem[i] = '0;
    @(posedge clk); #1 ram_clr = 1'b0;
    preload(10'd0, 32'h0000_0400);
    preload(10'd1, 32'h80F1_7F00);

    // Read strobe already low while reset is released.
    rd_n = 1'b0; addr = 32'h0; f3 = LW;
    @(negedge clk);
    check_output("reset busy w0", 32'(bus0.mem_busy_o), 32'd0);
    check_output("reset busy w3", 32'(bus3.mem_busy_o), 32'd0);
    check_output("reset ram_en w0", 32'(bus0.ram_en_o), 32'd0);
    check_rd("reset rd_data", 32'h0);
    @(posedge clk); #1 rst_n = 1'b1; in_reset = 1'b0;
    record_txn();
    repeat (8) @(posedge clk);
    #1 rd_n = 1'b1;
    check_rd("first LW", 32'h0000_0400);

    apply_stimulus(1'b0, 1'b1, 32'h6, 32'h0, LB);   check_rd("LB 0x6", 32'hFFFF_FFF1);
    apply_stimulus(1'b0, 1'b1, 32'h6, 32'h0, LBU);  check_rd("LBU 0x6", 32'h0000_00F1);
    apply_stimulus(1'b0, 1'b1, 32'h6, 32'h0, LH);   check_rd("LH 0x6", 32'hFFFF_80F1);
    apply_stimulus(1'b0, 1'b1, 32'h4, 32'h0, LHU);  check_rd("LHU 0x4", 32'h0000_7F00);

    apply_stimulus(1'b1, 1'b0, 32'h9, 32'hAB, LB);
    check_output("SB model we", 32'(t_we), 32'h2);
    check_output("SB model wdata", t_wdata, 32'hABAB_ABAB);
    apply_stimulus(1'b0, 1'b1, 32'h8, 32'h0, LW);   check_rd("LW 0x8", 32'h0000_AB00);

    apply_stimulus(1'b0, 1'b1, 32'h2, 32'h0, LW);   check_rd("LW 0x2 fault", 32'h0000_AB00);
    check_output("LW 0x2 model fault", 32'(t_fault), 32'd1);
    apply_stimulus(1'b1, 1'b0, 32'h1, 32'h5555, LH); check_rd("SH 0x1 fault", 32'h0000_AB00);
    apply_stimulus(1'b0, 1'b1, 32'h0, 32'h0, 3'b011); check_rd("f3 011 fault", 32'h0000_AB00);

    apply_stimulus(1'b0, 1'b0, 32'hC, 32'h1234_5678, LW);
    check_output("SW model we", 32'(t_we), 32'hF);

    for (int n = 0; n < 40; n++) begin
      automatic logic [31:0] a = ($urandom & 32'hFFFF_F000) | 32'h40 | 32'($urandom_range(0, 63));
      automatic int sel = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
      apply_stimulus(sel == 1, sel == 0, a, $urandom, 3'($urandom_range(0, 7)));
    end

    // Reset while the 3-wait-state instance is still waiting.
    @(posedge clk); #1;
    rd_n = 1'b0; wr_n = 1'b1; addr = 32'hC; f3 = LW;
    record_txn();
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0; in_reset = 1'b1;
    #1;
    check_output("midreset busy w0", 32'(bus0.mem_busy_o), 32'd0);
    check_output("midreset busy w3", 32'(bus3.mem_busy_o), 32'd0);
    check_output("midreset ram_en w3", 32'(bus3.ram_en_o), 32'd0);
    check_output("midreset fault w3", 32'(bus3.fault_o), 32'd0);
    check_rd("midreset rd_data", 32'h0);
    rd_n = 1'b1; t_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; in_reset = 1'b0;
    apply_stimulus(1'b0, 1'b1, 32'hC, 32'h0, LW);   check_rd("LW 0xC after reset", 32'h1234_5678);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
